// File: rtl/io_bank_pkg.sv
// Shared types and sizing for the GPIO bank tile; IO_BANK_PARITY_EN adds one even-parity chain bit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package io_bank_pkg;

  typedef enum logic [1:0] {
    CFG_IDLE  = 2'd0,
    CFG_SHIFT = 2'd1,
    CFG_FULL  = 2'd2,
    CFG_OVER  = 2'd3
  } cfg_state_e;

  localparam int DIR_BIT = 0;
  localparam int INV_BIT = 1;

`ifdef IO_BANK_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int chain_len(input int num_ch, input int cfg_bits, input bit parity_en);
    return num_ch * cfg_bits + (parity_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/io_bank_cfg_chain.sv
// Shadow/active config chain segment with length check and optional parity (IO_BANK_PARITY_EN).
// Latency: tail one prog_clk after each shift; active config, state and ack update on the commit edge.
// Backpressure: none; shifts beyond the chain length saturate the counter and poison the next commit.
module io_bank_cfg_chain
  import io_bank_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CFG_BITS = 2
) (
  input  logic                         prog_clk,
  input  logic                         pReset,
  input  logic                         ccff_head,
  input  logic                         ccff_shift_en,
  input  logic                         ccff_commit,
  output logic                         ccff_tail,
  output logic [NUM_CH*CFG_BITS-1:0]   active_cfg,
  output logic [1:0]                   cfg_state,
  output logic                         cfg_done,
  output logic                         cfg_err,
  output logic                         cfg_ack
);

  localparam int DATA_BITS = NUM_CH * CFG_BITS;
  localparam int L         = chain_len(NUM_CH, CFG_BITS, PARITY_EN);
  localparam int CW        = $clog2(L + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(L);
  localparam logic [CW-1:0] CNT_OVER = CW'(L + 1);

  logic [L-1:0]  shadow;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  cfg_state_e    state_q;
  cfg_state_e    state_nxt;
  logic          parity_ok;
  logic          commit_ok;

`ifdef IO_BANK_PARITY_EN
  // Parity bit sits at the top of the chain; even parity means the whole chain XORs to zero.
  assign parity_ok = ~^shadow;
`else
  assign parity_ok = 1'b1;
`endif

  assign commit_ok = ccff_commit && (state_q == CFG_FULL) && parity_ok;

  always_comb begin
    cnt_nxt = cnt;
    if (ccff_commit) begin
      cnt_nxt = '0;
    end else if (ccff_shift_en && (cnt != CNT_OVER)) begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  // State is registered from the next count so it always mirrors the live counter.
  always_comb begin
    state_nxt = CFG_OVER;
    if (cnt_nxt == '0) begin
      state_nxt = CFG_IDLE;
    end else if (cnt_nxt < CNT_FULL) begin
      state_nxt = CFG_SHIFT;
    end else if (cnt_nxt == CNT_FULL) begin
      state_nxt = CFG_FULL;
    end
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      shadow     <= '0;
      active_cfg <= '0;
      cnt        <= '0;
      state_q    <= CFG_IDLE;
      cfg_err    <= 1'b0;
      cfg_ack    <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      state_q <= state_nxt;
      cfg_ack <= commit_ok;
      if (ccff_commit) begin
        cfg_err <= !commit_ok;
        if (commit_ok) begin
          active_cfg <= shadow[DATA_BITS-1:0];
        end
      end else if (ccff_shift_en) begin
        shadow <= {shadow[L-2:0], ccff_head};
      end
    end
  end

  assign ccff_tail = shadow[L-1];
  assign cfg_state = state_q;
  assign cfg_done  = (state_q == CFG_FULL);

endmodule

// File: rtl/logical_tile_io_bank.sv
// GPIO bank tile: NUM_CH pad cells configured by one shadow/active chain segment (IO_BANK_PARITY_EN optional).
// Latency: pad data path is combinational; config takes effect on the accepted commit edge.
// Backpressure: none; a bad-length or bad-parity commit is dropped and flagged on cfg_err.
module logical_tile_io_bank
  import io_bank_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CFG_BITS = 2
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              ccff_head,
  input  logic              ccff_shift_en,
  input  logic              ccff_commit,
  output logic              ccff_tail,
  inout  wire  [NUM_CH-1:0] gfpga_pad_GPIO_PAD,
  input  logic [NUM_CH-1:0] iopad_outpad,
  output logic [NUM_CH-1:0] iopad_inpad,
  output logic [1:0]        cfg_state,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic              cfg_ack
);

  logic [NUM_CH*CFG_BITS-1:0] active_cfg;

  io_bank_cfg_chain #(
    .NUM_CH   (NUM_CH),
    .CFG_BITS (CFG_BITS)
  ) u_cfg_chain (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_commit   (ccff_commit),
    .ccff_tail     (ccff_tail),
    .active_cfg    (active_cfg),
    .cfg_state     (cfg_state),
    .cfg_done      (cfg_done),
    .cfg_err       (cfg_err),
    .cfg_ack       (cfg_ack)
  );

  // Input path stays live even when driving, so the fabric can read back its own output.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_gpio_cell
    logic dir;
    logic inv;
    assign dir = active_cfg[c*CFG_BITS + DIR_BIT];
    assign inv = active_cfg[c*CFG_BITS + INV_BIT];
    assign gfpga_pad_GPIO_PAD[c] = dir ? (iopad_outpad[c] ^ inv) : 1'bz;
    assign iopad_inpad[c] = gfpga_pad_GPIO_PAD[c] ^ inv;
  end

endmodule

// File: tb/tb_logical_tile_io_bank.sv
// Directed bench for logical_tile_io_bank with a tail-bit scoreboard and a pad/inpad model.
module tb_logical_tile_io_bank;
  import io_bank_pkg::*;

  localparam int NUM_CH    = 4;
  localparam int CFG_BITS  = 2;
  localparam int DATA_BITS = NUM_CH * CFG_BITS;
  localparam int L         = chain_len(NUM_CH, CFG_BITS, PARITY_EN);

  logic        prog_clk = 1'b0;
  logic        pReset;
  logic        ccff_head;
  logic        ccff_shift_en;
  logic        ccff_commit;
  logic        ccff_tail;
  wire  [3:0]  pad;
  logic [3:0]  outpad;
  logic [3:0]  inpad;
  logic [1:0]  cfg_state;
  logic        cfg_done;
  logic        cfg_err;
  logic        cfg_ack;

  logic [3:0]  tb_en;
  logic [3:0]  tb_val;
  logic [7:0]  exp_active;
  bit          tail_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 prog_clk = ~prog_clk;

  for (genvar i = 0; i < 4; i++) begin : g_pad_drv
    assign pad[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  logical_tile_io_bank #(
    .NUM_CH   (NUM_CH),
    .CFG_BITS (CFG_BITS)
  ) dut (
    .prog_clk           (prog_clk),
    .pReset             (pReset),
    .ccff_head          (ccff_head),
    .ccff_shift_en      (ccff_shift_en),
    .ccff_commit        (ccff_commit),
    .ccff_tail          (ccff_tail),
    .gfpga_pad_GPIO_PAD (pad),
    .iopad_outpad       (outpad),
    .iopad_inpad        (inpad),
    .cfg_state          (cfg_state),
    .cfg_done           (cfg_done),
    .cfg_err            (cfg_err),
    .cfg_ack            (cfg_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] dir_of(input logic [7:0] a);
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = a[c*2];
    return r;
  endfunction

  function automatic logic [3:0] inv_of(input logic [7:0] a);
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = a[c*2+1];
    return r;
  endfunction

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic check_pads(input string tag);
    logic [3:0] d;
    logic [3:0] v;
    logic [3:0] ep;
    d  = dir_of(exp_active);
    v  = inv_of(exp_active);
    ep = (d & (outpad ^ v)) | (~d & tb_val);
    chk({tag, ".pad"}, pad, ep);
    chk({tag, ".inpad"}, inpad, ep ^ v);
  endtask

  task automatic shift_bit(input bit b);
    ccff_head     = b;
    ccff_shift_en = 1'b1;
    step();
    ccff_shift_en = 1'b0;
    tail_q.push_back(b);
    chk("tail", ccff_tail, tail_q.pop_front());
  endtask

  task automatic shift_stream(input logic [7:0] data, input bit bad_par);
    logic [L-1:0] s;
    s = '0;
    s[DATA_BITS-1:0] = data;
    if (L > DATA_BITS) s[L-1] = (^data) ^ bad_par;
    for (int i = L - 1; i >= 0; i--) shift_bit(s[i]);
  endtask

  task automatic commit(input bit ok, input logic [7:0] new_cfg, input bit also_shift, input string tag);
    if (ok) tb_en = ~dir_of(exp_active) & ~dir_of(new_cfg);
    ccff_commit   = 1'b1;
    ccff_shift_en = also_shift;
    ccff_head     = 1'b1;
    step();
    ccff_commit   = 1'b0;
    ccff_shift_en = 1'b0;
    if (ok) exp_active = new_cfg;
    tb_en = ~dir_of(exp_active);
    #1;
    chk({tag, ".ack"}, cfg_ack, ok);
    chk({tag, ".err"}, cfg_err, !ok);
    chk({tag, ".state"}, cfg_state, CFG_IDLE);
    chk({tag, ".done"}, cfg_done, 1'b0);
    check_pads(tag);
    step();
    chk({tag, ".ack_low"}, cfg_ack, 1'b0);
  endtask

  task automatic refill_tail_q();
    tail_q.delete();
    for (int i = 0; i < L - 1; i++) tail_q.push_back(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    pReset        = 1'b0;
    ccff_head     = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_commit   = 1'b0;
    outpad        = 4'b0000;
    tb_en         = 4'hF;
    tb_val        = 4'b1010;
    exp_active    = 8'h00;
    refill_tail_q();
    #2;
    chk("rst.state", cfg_state, CFG_IDLE);
    chk("rst.tail", ccff_tail, 1'b0);
    chk("rst.done", cfg_done, 1'b0);
    chk("rst.err", cfg_err, 1'b0);
    chk("rst.ack", cfg_ack, 1'b0);
    check_pads("rst");
    @(negedge prog_clk);
    pReset = 1'b1;
    step();

    // ch0 drive, ch2 drive inverted
    outpad = 4'b0101;
    shift_stream(8'h31, 1'b0);
    chk("a.full_state", cfg_state, CFG_FULL);
    chk("a.full_done", cfg_done, 1'b1);
    commit(1'b1, 8'h31, 1'b0, "cfgA");
    outpad = 4'b1010;
    tb_val = 4'b0110;
    #1;
    check_pads("cfgA.pat2");

    // short stream rejected
    shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0);
    chk("short.state", cfg_state, CFG_SHIFT);
    commit(1'b0, 8'h00, 1'b0, "short");
    shift_stream(8'h84, 1'b0);
    commit(1'b1, 8'h84, 1'b0, "cfgB");

    // one bit too many
    shift_stream(8'h5A, 1'b0);
    shift_bit(1'b1);
    chk("over.state", cfg_state, CFG_OVER);
    chk("over.done", cfg_done, 1'b0);
    commit(1'b0, 8'h00, 1'b0, "over");

    // async reset in the middle of a shift
    shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1);
    @(negedge prog_clk);
    pReset = 1'b0;
    #1;
    tb_en      = 4'hF;
    exp_active = 8'h00;
    #1;
    chk("midrst.state", cfg_state, CFG_IDLE);
    chk("midrst.tail", ccff_tail, 1'b0);
    chk("midrst.err", cfg_err, 1'b0);
    check_pads("midrst");
    refill_tail_q();
    @(negedge prog_clk);
    pReset = 1'b1;
    step();

    // commit and shift together: commit wins, shadow holds
    outpad = 4'b0011;
    shift_stream(8'h13, 1'b0);
    commit(1'b1, 8'h13, 1'b1, "both");
    shift_bit(1'b0);
    chk("both.cnt_restart", cfg_state, CFG_SHIFT);

`ifdef IO_BANK_PARITY_EN
    shift_stream(8'hC6, 1'b1);
    chk("badpar.state", cfg_state, CFG_FULL);
    commit(1'b0, 8'h00, 1'b0, "badpar");
    shift_stream(8'hC6, 1'b0);
    commit(1'b1, 8'hC6, 1'b0, "goodpar");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
